// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Ports: clk, rst_n (sync, active-low), start/a/b/bin in; busy/done/diff/bout/ovf out.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_brn;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_nx;

  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_brn    = (~w_ai & w_bi)
                  | (~(w_ai ^ w_bi) & r_br);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_res_nx = {w_d, r_res[WIDTH-1:1]};
  // A new request is taken in IDLE, or in DONE
  // for back-to-back operation; never in RUN.
  assign w_accept = start
                  & ((r_state == S_IDLE)
                  |  (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      busy <= (w_next == S_RUN);
      done <= (w_next == S_DONE);
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bin;
        r_res <= '0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_brn;
        r_res <= w_res_nx;
        r_cnt <= r_cnt + CW'(1);
        // Final step: a_i/b_i are the operand
        // MSBs and w_d is the result MSB.
        if (w_last) begin
          diff <= w_res_nx;
          bout <= w_brn;
          ovf  <= (w_ai != w_bi)
                & (w_d != w_ai);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4).
// Hand-computed vectors, latency, back-to-back and reset abort.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Single operation; inputs are scrambled right
  // after acceptance to show they are not re-read.
  task automatic op(input string tag,
                    input logic [W-1:0] ta,
                    input logic [W-1:0] tb_,
                    input logic tbin,
                    input logic [W-1:0] ed,
                    input logic eb,
                    input logic eo);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
    check({tag, "/run1"}, 32'({busy, done}), 32'h2);
    repeat (W - 1) @(negedge clk);
    check({tag, "/runW"}, 32'({busy, done}), 32'h2);
    @(negedge clk);
    check({tag, "/done"}, 32'({busy, done}), 32'h1);
    check({tag, "/res"}, 32'({diff, bout, ovf}),
          32'({ed, eb, eo}));
    @(negedge clk);
    check({tag, "/idle"}, 32'({busy, done}), 32'h0);
    check({tag, "/hold"}, 32'({diff, bout, ovf}),
          32'({ed, eb, eo}));
  endtask

  initial begin
    int dones;
    int dc1;
    int dc2;
    logic [W+1:0] r1;
    logic [W+1:0] r2;

    repeat (3) @(negedge clk);
    check("reset", 32'({busy, done, diff, bout, ovf}),
          32'h0);
    rst_n = 1'b1;

    op("5-3",   4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    op("3-5",   4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0);
    op("0-0-1", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
    op("-8-1",  4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
    op("7-(-1)",4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1);

    // start re-pulsed in RUN must be ignored
    @(negedge clk);
    a = 4'b1001; b = 4'b0100; bin = 1'b0; start = 1'b1;
    dones = 0; dc1 = 0; r1 = '0;
    for (int c = 1; c <= W + 4; c++) begin
      @(negedge clk);
      if (done) begin
        dones++; dc1 = c; r1 = {diff, bout, ovf};
      end
      start = (c == 2);
      if (c == 2) begin
        a = 4'b1111; b = 4'b0000;
      end
    end
    check("ign/count", 32'(dones), 32'd1);
    check("ign/cycle", 32'(dc1), 32'(W + 1));
    check("ign/res", 32'(r1), 32'({4'b0101, 1'b0, 1'b1}));

    // start held through DONE: back-to-back
    @(negedge clk);
    a = 4'b0010; b = 4'b0101; bin = 1'b0; start = 1'b1;
    dones = 0; dc1 = 0; dc2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 2 * W + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a = 4'b1100; b = 4'b0011; bin = 1'b1;
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          dc1 = c; r1 = {diff, bout, ovf};
        end else begin
          dc2 = c; r2 = {diff, bout, ovf};
        end
      end
      if (c == W + 2)
        check("b2b/busy", 32'({busy, done}), 32'h2);
      start = (c <= W + 1);
    end
    check("b2b/count", 32'(dones), 32'd2);
    check("b2b/first", 32'(dc1), 32'(W + 1));
    check("b2b/gap", 32'(dc2 - dc1), 32'(W + 1));
    check("b2b/res1", 32'(r1), 32'({4'b1101, 1'b1, 1'b0}));
    check("b2b/res2", 32'(r2), 32'({4'b1000, 1'b0, 1'b0}));

    // reset in RUN cycle 2 aborts the operation
    @(negedge clk);
    a = 4'b0101; b = 4'b0010; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort/out", 32'({busy, done, diff, bout, ovf}),
          32'h0);
    dones = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort/nodone", 32'(dones), 32'd0);
    op("post", 4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
